bandwidth_check: RTL and testbench
==================================

BANDWIDTH_CHECK -- requirements
Module: bandwidth_check

Interface
REQ-001 XFER_BEATS, default 32'h0200_0000: number of beats per test; legal range 1 to 2^32-1.
REQ-002 TIMEOUT_CYCLES, default 32'd250_000_000: idle cycles that abort a test; used only when BWCHECK_TIMEOUT_EN is defined.
REQ-003 clock  input  1: the single clock; all logic on its rising edge.
REQ-004 reset  input  1: synchronous, active-high.
REQ-005 IN_AXIS_TDATA  input  256: beat payload; only [63:0] is checked, [255:64] is ignored.
REQ-006 IN_AXIS_TVALID  input  1: the sender has a beat valid.
REQ-007 IN_AXIS_TLAST  input  1: the sender marks every beat as last.
REQ-008 IN_AXIS_TREADY  output  1: registered ready.
REQ-009 rx_time  output  64: cycles from the first accepted beat to the final accepted beat of the last completed test.
REQ-010 rx_beats  output  32: beats accepted in the last completed test.
REQ-011 seq_errors  output  32: non-increasing sequence violations in the last completed test.
REQ-012 last_errors  output  32: beats accepted with TLAST=0 in the last completed test.
REQ-013 test_done  output  1: one-cycle pulse when the result outputs update.
REQ-014 busy  output  1: high while a test is in progress (RUN state).
REQ-015 timed_out  output  1: the last completed test ended by timeout.

Function
REQ-016 A beat is accepted when IN_AXIS_TVALID and IN_AXIS_TREADY are both high on a rising edge.
REQ-017 A free-running 64-bit cycle counter increments every cycle and wraps modulo 2^64; the rx_time subtraction is also modulo 2^64.
REQ-018 States: IDLE, RUN, REPORT.
REQ-019 IDLE, beat accepted:
  - latch the cycle counter as the start count;
  - latch TDATA[63:0] as the previous value;
  - set the live beat count to 1;
  - check TLAST;
  - if XFER_BEATS=1 go to REPORT, otherwise go to RUN.
REQ-020 RUN, each accepted beat:
  - increment the live beat count;
  - if TDATA[63:0] <= previous (unsigned), increment the live seq count;
  - if TLAST=0, increment the live last count;
  - update previous to TDATA[63:0].
REQ-021 RUN: when the live beat count reaches XFER_BEATS, latch the end count and go to REPORT.
REQ-022 REPORT lasts exactly one cycle:
  - publish rx_time = end - start, plus rx_beats, seq_errors, last_errors, timed_out;
  - pulse test_done;
  - clear the live counters;
  - return to IDLE.
REQ-023 IN_AXIS_TREADY is 0 in the REPORT cycle and 1 in all other non-reset cycles; no beat is accepted in REPORT.
REQ-024 The first beat of a test is never checked for sequence errors.
REQ-025 The live seq and live last counts saturate at 32'hFFFF_FFFF.
REQ-026 Result outputs hold their values between REPORT cycles.
REQ-027 busy = 1 exactly while the state is RUN.

Reset
REQ-028 While reset is high:
  - state = IDLE, cycle counter = 0, IN_AXIS_TREADY = 0;
  - rx_time, rx_beats, seq_errors, last_errors = 0;
  - test_done, busy, timed_out = 0;
  - live counters = 0.
REQ-029 IN_AXIS_TREADY rises in the first cycle after reset deasserts.
REQ-030 Reset asserted mid-test discards the test with no test_done pulse.

Configuration
REQ-031 Macro BWCHECK_TIMEOUT_EN.
REQ-032 With BWCHECK_TIMEOUT_EN defined:
  - an idle counter clears on each accepted beat and increments every RUN cycle with no accepted beat;
  - when it reaches TIMEOUT_CYCLES, the latched end count is the cycle of the last accepted beat;
  - the block enters REPORT with timed_out = 1 and rx_beats = the live beat count.
REQ-033 Without BWCHECK_TIMEOUT_EN, the idle counter is not built, RUN waits indefinitely, and timed_out is tied to 0.

Verification
REQ-034 XFER_BEATS=4; beats 10, 11, 12, 13 back-to-back with TLAST=1 -> test_done, rx_time=3, rx_beats=4, seq_errors=0, last_errors=0.
REQ-035 XFER_BEATS=4; two idle cycles between each beat -> rx_time=9, and TREADY=0 only in the REPORT cycle.
REQ-036 XFER_BEATS=4; data 10, 20, 15, 30 -> seq_errors=1; then data 5, 5, 5, 5 -> seq_errors=3.
REQ-037 XFER_BEATS=4; TLAST=0 on beat 2 -> last_errors=1, seq_errors=0.
REQ-038 BWCHECK_TIMEOUT_EN, TIMEOUT_CYCLES=16, XFER_BEATS=8; send 2 beats, then stop -> 16 cycles later test_done, timed_out=1, rx_beats=2, rx_time=1.
REQ-039 Reset for one cycle after 2 of 4 beats -> all outputs 0, no test_done; a following clean 4-beat run -> rx_beats=4.

Source files
------------

// File: rtl/bandwidth_check.sv
// AXI-Stream receive bandwidth checker: times a fixed-length burst and counts sequence/TLAST errors.
// Optional idle-timeout abort is built when BWCHECK_TIMEOUT_EN is defined.
module bandwidth_check #(
  parameter logic [31:0] XFER_BEATS     = 32'h0200_0000,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd250_000_000
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [255:0] IN_AXIS_TDATA,
  input  logic         IN_AXIS_TVALID,
  input  logic         IN_AXIS_TLAST,
  output logic         IN_AXIS_TREADY,
  output logic [63:0]  rx_time,
  output logic [31:0]  rx_beats,
  output logic [31:0]  seq_errors,
  output logic [31:0]  last_errors,
  output logic         test_done,
  output logic         busy,
  output logic         timed_out
);

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned TIME_W = 64;
  localparam int unsigned SEQ_W  = 64;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_REPORT} state_t;

  state_t            state_q, state_d;
  logic [TIME_W-1:0] cyc_q;
  logic [TIME_W-1:0] start_q, start_d;
  logic [TIME_W-1:0] end_q, end_d;
  logic [SEQ_W-1:0]  prev_q, prev_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]  seq_q, seq_d;
  logic [CNT_W-1:0]  lerr_q, lerr_d;
  logic              timeout_d;
  logic              accept_c;
  logic [SEQ_W-1:0]  data_c;
  logic              unused_tdata_c;

`ifdef BWCHECK_TIMEOUT_EN
  logic [CNT_W-1:0]  idle_q, idle_d;
`else
  logic [CNT_W-1:0]  unused_timeout_c;
  assign unused_timeout_c = TIMEOUT_CYCLES;
`endif

  assign accept_c       = IN_AXIS_TVALID && IN_AXIS_TREADY;
  assign data_c         = IN_AXIS_TDATA[SEQ_W-1:0];
  assign unused_tdata_c = ^IN_AXIS_TDATA[255:SEQ_W];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and live-counter update; end count tracks every accepted beat
  always_comb begin
    state_d   = state_q;
    start_d   = start_q;
    end_d     = end_q;
    prev_d    = prev_q;
    beat_d    = beat_q;
    seq_d     = seq_q;
    lerr_d    = lerr_q;
    timeout_d = 1'b0;
`ifdef BWCHECK_TIMEOUT_EN
    idle_d    = idle_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          start_d = cyc_q;
          end_d   = cyc_q;
          prev_d  = data_c;
          beat_d  = CNT_W'(1);
          seq_d   = '0;
          lerr_d  = IN_AXIS_TLAST ? '0 : CNT_W'(1);
`ifdef BWCHECK_TIMEOUT_EN
          idle_d  = '0;
`endif
          state_d = (XFER_BEATS == CNT_W'(1)) ? S_REPORT : S_RUN;
        end
      end
      S_RUN: begin
        if (accept_c) begin
          end_d  = cyc_q;
          prev_d = data_c;
          beat_d = beat_q + CNT_W'(1);
          if (data_c <= prev_q) seq_d  = sat_inc(seq_q);
          if (!IN_AXIS_TLAST)   lerr_d = sat_inc(lerr_q);
`ifdef BWCHECK_TIMEOUT_EN
          idle_d = '0;
`endif
          if (beat_d == XFER_BEATS) state_d = S_REPORT;
        end
`ifdef BWCHECK_TIMEOUT_EN
        else begin
          idle_d = idle_q + CNT_W'(1);
          if (idle_d == TIMEOUT_CYCLES) begin
            state_d   = S_REPORT;
            timeout_d = 1'b1;
          end
        end
`endif
      end
      S_REPORT: begin
        beat_d  = '0;
        seq_d   = '0;
        lerr_d  = '0;
`ifdef BWCHECK_TIMEOUT_EN
        idle_d  = '0;
`endif
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers and results; results publish on entry to REPORT so test_done aligns with it
  always_ff @(posedge clock) begin
    if (reset) begin
      cyc_q          <= '0;
      start_q        <= '0;
      end_q          <= '0;
      prev_q         <= '0;
      beat_q         <= '0;
      seq_q          <= '0;
      lerr_q         <= '0;
`ifdef BWCHECK_TIMEOUT_EN
      idle_q         <= '0;
`endif
      IN_AXIS_TREADY <= 1'b0;
      busy           <= 1'b0;
      test_done      <= 1'b0;
      rx_time        <= '0;
      rx_beats       <= '0;
      seq_errors     <= '0;
      last_errors    <= '0;
      timed_out      <= 1'b0;
    end else begin
      cyc_q          <= cyc_q + TIME_W'(1);
      start_q        <= start_d;
      end_q          <= end_d;
      prev_q         <= prev_d;
      beat_q         <= beat_d;
      seq_q          <= seq_d;
      lerr_q         <= lerr_d;
`ifdef BWCHECK_TIMEOUT_EN
      idle_q         <= idle_d;
`endif
      IN_AXIS_TREADY <= (state_d != S_REPORT);
      busy           <= (state_d == S_RUN);
      test_done      <= (state_d == S_REPORT);
      if (state_d == S_REPORT) begin
        rx_time     <= end_d - start_d;
        rx_beats    <= beat_d;
        seq_errors  <= seq_d;
        last_errors <= lerr_d;
        timed_out   <= timeout_d;
      end
    end
  end

endmodule

// File: tb/tb_bandwidth_check.sv
// Scoreboard bench for bandwidth_check (XFER_BEATS=4); adds a timeout instance when BWCHECK_TIMEOUT_EN is defined.
module tb_bandwidth_check;

  typedef struct packed {
    logic [63:0] t;
    logic [31:0] b;
    logic [31:0] s;
    logic [31:0] l;
    logic        to;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] data  = '0;
  logic         valid = 1'b0;
  logic         last  = 1'b1;
  logic         tready;
  logic [63:0]  rx_time;
  logic [31:0]  rx_beats, seq_errors, last_errors;
  logic         test_done, busy, timed_out;

  int   checks   = 0;
  int   failures = 0;
  logic chk_rdy  = 1'b0;
  exp_t q[$];

  always #5 clock = ~clock;

  bandwidth_check #(.XFER_BEATS(32'd4), .TIMEOUT_CYCLES(32'd1000)) dut (
    .clock(clock), .reset(reset),
    .IN_AXIS_TDATA(data), .IN_AXIS_TVALID(valid), .IN_AXIS_TLAST(last),
    .IN_AXIS_TREADY(tready),
    .rx_time(rx_time), .rx_beats(rx_beats), .seq_errors(seq_errors),
    .last_errors(last_errors), .test_done(test_done), .busy(busy), .timed_out(timed_out)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Called at a negedge; holds the beat until accepted, returns at the next negedge
  task automatic send(input logic [63:0] d, input logic l);
    int n = 0;
    valid = 1'b1;
    data  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), d};
    last  = l;
    while (!tready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n >= 20) check("send_ready_wait", 64'(tready), 64'd1);
    @(negedge clock);
    valid = 1'b0;
    last  = 1'b1;
  endtask

  task automatic run4(input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                      input logic [63:0] d3, input logic [3:0] l, input int gap,
                      input logic [63:0] et, input logic [31:0] es, input logic [31:0] el);
    q.push_back('{t: et, b: 32'd4, s: es, l: el, to: 1'b0});
    send(d0, l[0]); repeat (gap) @(negedge clock);
    send(d1, l[1]); repeat (gap) @(negedge clock);
    send(d2, l[2]); repeat (gap) @(negedge clock);
    send(d3, l[3]);
  endtask

  // Monitor: pops the scoreboard on every test_done and tracks ready behaviour
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (chk_rdy) check("tready_vs_report", 64'(tready), 64'(!test_done));
      if (test_done) begin
        if (q.size() == 0) begin
          check("unexpected_test_done", 64'(test_done), 64'd0);
        end else begin
          e = q.pop_front();
          check("rx_time",     rx_time,            e.t);
          check("rx_beats",    64'(rx_beats),      64'(e.b));
          check("seq_errors",  64'(seq_errors),    64'(e.s));
          check("last_errors", 64'(last_errors),   64'(e.l));
          check("timed_out",   64'(timed_out),     64'(e.to));
        end
      end
    end
  end

`ifdef BWCHECK_TIMEOUT_EN
  logic [255:0] data2  = '0;
  logic         valid2 = 1'b0;
  logic         tready2;
  logic [63:0]  rx_time2;
  logic [31:0]  rx_beats2, seq_errors2, last_errors2;
  logic         test_done2, busy2, timed_out2;
  exp_t         q2[$];

  bandwidth_check #(.XFER_BEATS(32'd8), .TIMEOUT_CYCLES(32'd16)) dut_to (
    .clock(clock), .reset(reset),
    .IN_AXIS_TDATA(data2), .IN_AXIS_TVALID(valid2), .IN_AXIS_TLAST(1'b1),
    .IN_AXIS_TREADY(tready2),
    .rx_time(rx_time2), .rx_beats(rx_beats2), .seq_errors(seq_errors2),
    .last_errors(last_errors2), .test_done(test_done2), .busy(busy2), .timed_out(timed_out2)
  );

  always @(negedge clock) begin
    exp_t e;
    if (!reset && test_done2) begin
      if (q2.size() == 0) begin
        check("to_unexpected_test_done", 64'(test_done2), 64'd0);
      end else begin
        e = q2.pop_front();
        check("to_rx_time",   rx_time2,         e.t);
        check("to_rx_beats",  64'(rx_beats2),   64'(e.b));
        check("to_seq",       64'(seq_errors2), 64'(e.s));
        check("to_timed_out", 64'(timed_out2),  64'(e.to));
      end
    end
  end
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    repeat (3) @(negedge clock);
    check("reset_tready",    64'(tready),      64'd0);
    check("reset_rx_time",   rx_time,          64'd0);
    check("reset_rx_beats",  64'(rx_beats),    64'd0);
    check("reset_test_done", 64'(test_done),   64'd0);
    check("reset_busy",      64'(busy),        64'd0);
    check("reset_timed_out", 64'(timed_out),   64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("tready_after_reset", 64'(tready), 64'd1);
    chk_rdy = 1'b1;

    run4(64'd10, 64'd11, 64'd12, 64'd13, 4'b1111, 0, 64'd3, 32'd0, 32'd0);
    run4(64'd10, 64'd11, 64'd12, 64'd13, 4'b1111, 2, 64'd9, 32'd0, 32'd0);
    run4(64'd10, 64'd20, 64'd15, 64'd30, 4'b1111, 0, 64'd3, 32'd1, 32'd0);
    run4(64'd5,  64'd5,  64'd5,  64'd5,  4'b1111, 0, 64'd3, 32'd3, 32'd0);
    run4(64'd1,  64'd2,  64'd3,  64'd4,  4'b1101, 0, 64'd3, 32'd0, 32'd1);
    run4(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd1, 64'd2, 4'b0000, 1, 64'd6, 32'd1, 32'd4);

    n = 0;
    while (q.size() != 0 && n < 50) begin @(negedge clock); n++; end
    check("scoreboard_drained", 64'(q.size()), 64'd0);

    // Abort a test part-way with a one-cycle reset
    @(negedge clock);
    send(64'd1, 1'b1);
    send(64'd2, 1'b1);
    check("busy_mid_test", 64'(busy), 64'd1);
    chk_rdy = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("midreset_tready",      64'(tready),      64'd0);
    check("midreset_rx_time",     rx_time,          64'd0);
    check("midreset_rx_beats",    64'(rx_beats),    64'd0);
    check("midreset_seq_errors",  64'(seq_errors),  64'd0);
    check("midreset_last_errors", 64'(last_errors), 64'd0);
    check("midreset_busy",        64'(busy),        64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("tready_after_midreset", 64'(tready), 64'd1);
    chk_rdy = 1'b1;
    run4(64'd7, 64'd8, 64'd9, 64'd10, 4'b1111, 0, 64'd3, 32'd0, 32'd0);

`ifdef BWCHECK_TIMEOUT_EN
    q2.push_back('{t: 64'd1, b: 32'd2, s: 32'd0, l: 32'd0, to: 1'b1});
    valid2 = 1'b1; data2 = 256'd1;
    @(negedge clock);
    data2 = 256'd2;
    @(negedge clock);
    valid2 = 1'b0;
    n = 0;
    while (q2.size() != 0 && n < 60) begin @(negedge clock); n++; end
    check("to_scoreboard_drained", 64'(q2.size()), 64'd0);
`endif

    n = 0;
    while (q.size() != 0 && n < 50) begin @(negedge clock); n++; end
    check("final_scoreboard_drained", 64'(q.size()), 64'd0);
    repeat (5) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
